// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending-write scoreboard
// Ports: NRD combinational read ports (rs_addr/rs_data/rs_busy), one write-back port
// (wb_en/wb_addr/wb_data), issue-side allocation (alloc_en/alloc_addr -> alloc_ok),
// pipeline flush, and busy_count (number of pending registers). Register 0 reads as zero.
// Macro REGFILE_BYPASS_EN: forward same-cycle write-back data to matching read ports.
module regfile_scoreboard #(
  parameter int XLEN = 64,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]    rs_busy,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_ok,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [AW:0]       busy_count
);
`ifdef REGFILE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  localparam int CW = AW + 1;
  logic [XLEN-1:0] regs_q [NREGS-1:1];
  logic [XLEN-1:0] regs_d [NREGS-1:1];
  logic [XLEN-1:0] regs_rd [NREGS];
  logic [NREGS-1:1] busy_q, busy_d;
  logic [NREGS-1:0] busy_rd, busy_n;
  logic [AW:0] busy_count_q, busy_count_d;
  // Full-width views with a constant-zero entry 0, so x0 needs no special read path.
  always_comb begin
    regs_rd[0] = '0;
    for (int k = 1; k < NREGS; k++) regs_rd[k] = regs_q[k];
  end
  assign busy_rd = {busy_q, 1'b0};
  // busy_rd[0] is 0, which covers the alloc_addr == 0 case.
  assign alloc_ok = alloc_en & ~flush & (~busy_rd[alloc_addr] | (wb_en & (wb_addr == alloc_addr)));
  // Order matters: write-back clears, flush clears all, then an accepted allocation sets last.
  always_comb begin
    busy_n = busy_rd;
    if (wb_en) busy_n[wb_addr] = 1'b0;
    if (flush) busy_n = '0;
    if (alloc_ok) busy_n[alloc_addr] = 1'b1;
    busy_n[0] = 1'b0;
    busy_d = busy_n[NREGS-1:1];
    busy_count_d = '0;
    for (int k = 1; k < NREGS; k++) busy_count_d = busy_count_d + CW'(busy_n[k]);
    for (int k = 1; k < NREGS; k++) regs_d[k] = (wb_en && wb_addr == AW'(k)) ? wb_data : regs_q[k];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end
  assign busy_count = busy_count_q;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic fwd;
    assign a = rs_addr[i*AW +: AW];
    assign fwd = BYPASS & wb_en & (wb_addr == a) & (a != '0);
    assign rs_data[i*XLEN +: XLEN] = fwd ? wb_data : regs_rd[a];
    assign rs_busy[i] = ~fwd & busy_rd[a];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench with a behavioural register-file model
module tb_regfile_scoreboard;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0] rs_busy;
  logic alloc_en, alloc_ok, wb_en, flush;
  logic [AW-1:0] alloc_addr, wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [AW:0] busy_count;
  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(alloc_ok),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .busy_count(busy_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0] b;
    logic ok;
    logic [AW:0] cnt;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [XLEN-1:0] mem [NREGS];
  bit pend [NREGS];
  function automatic bit model_ok();
    return alloc_en && !flush && (alloc_addr == 0 || !pend[alloc_addr] || (wb_en && wb_addr == alloc_addr));
  endfunction
  function automatic exp_t predict();
    exp_t e;
    int c = 0;
    e.ok = model_ok();
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] a;
      a = rs_addr[p*AW +: AW];
      if (a == 0) begin
        e.d[p*XLEN +: XLEN] = '0;
        e.b[p] = 1'b0;
      end else if (BYP && wb_en && wb_addr == a) begin
        e.d[p*XLEN +: XLEN] = wb_data;
        e.b[p] = 1'b0;
      end else begin
        e.d[p*XLEN +: XLEN] = mem[a];
        e.b[p] = pend[a];
      end
    end
    for (int r = 1; r < NREGS; r++) c += int'(pend[r]);
    e.cnt = (AW+1)'(c);
    return e;
  endfunction
  task automatic commit();
    bit ok;
    ok = model_ok();
    if (wb_en && wb_addr != 0) begin
      mem[wb_addr] = wb_data;
      pend[wb_addr] = 1'b0;
    end
    if (flush) for (int r = 0; r < NREGS; r++) pend[r] = 1'b0;
    if (ok && alloc_addr != 0) pend[alloc_addr] = 1'b1;
  endtask
  task automatic clear_model();
    for (int r = 0; r < NREGS; r++) begin
      mem[r] = '0;
      pend[r] = 1'b0;
    end
  endtask
  // Apply one cycle of stimulus (called at posedge+1), queue its expectation, cross the edge.
  task automatic drive(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic ae,
                       input logic [AW-1:0] aa, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic fl);
    rs_addr = {r1, r0};
    alloc_en = ae;
    alloc_addr = aa;
    wb_en = we;
    wb_addr = wa;
    wb_data = wd;
    flush = fl;
    q.push_back(predict());
    @(posedge clk);
    commit();
    #1;
  endtask
  task automatic rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    drive(r0, r1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    rs_addr = {AW'(4), AW'(4)};
    alloc_en = 1'b0;
    wb_en = 1'b0;
    flush = 1'b0;
    clear_model();
    q.push_back(predict());
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rs_data", 128'(rs_data), 128'(e.d));
        chk("rs_busy", 128'(rs_busy), 128'(e.b));
        chk("alloc_ok", 128'(alloc_ok), 128'(e.ok));
        chk("busy_count", 128'(busy_count), 128'(e.cnt));
      end
    end
  end
  initial begin
    clear_model();
    reset_n = 1'b0;
    rs_addr = '0;
    alloc_en = 1'b0;
    alloc_addr = '0;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    flush = 1'b0;
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < NREGS; a++) rd(AW'(a), AW'(NREGS - 1 - a));
    drive(0, 0, 1'b0, 0, 1'b1, 0, 64'hDEAD, 1'b0);
    rd(0, 0);
    drive(5, 5, 1'b1, 5, 1'b0, 0, 0, 1'b0);
    drive(5, 0, 1'b1, 5, 1'b0, 0, 0, 1'b0);
    drive(5, 5, 1'b0, 0, 1'b1, 5, 64'h1234, 1'b0);
    rd(5, 5);
    drive(0, 7, 1'b1, 7, 1'b0, 0, 0, 1'b0);
    drive(7, 7, 1'b1, 7, 1'b1, 7, 64'hAA, 1'b0);
    rd(7, 7);
    for (int a = 1; a < NREGS; a++) drive(AW'(a), 0, 1'b1, AW'(a), 1'b0, 0, 0, 1'b0);
    rd(3, 2);
    drive(3, 2, 1'b1, 3, 1'b1, 2, 64'h55, 1'b1);
    rd(3, 2);
    drive(0, 9, 1'b0, 0, 1'b1, 9, 64'hBEEF, 1'b0);
    rd(0, 9);
    drive(4, 0, 1'b0, 0, 1'b1, 4, 64'h77, 1'b0);
    drive(4, 4, 1'b1, 4, 1'b0, 0, 0, 1'b0);
    rd(4, 4);
    reset_pulse();
    rd(4, 4);
    for (int n = 0; n < 400; n++)
      drive(AW'($urandom), AW'($urandom), 1'($urandom), AW'($urandom_range(0, 7)),
            1'($urandom), AW'($urandom_range(0, 7)), {$urandom, $urandom}, $urandom_range(0, 15) == 0);
    for (int n = 0; n < 10 && q.size() != 0; n++) @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
